// File: rtl/fp_add_sequencer_pkg.sv
// Shared types and constants for the FP adder sequencer.
// Holds the sequencer state encoding and the single-precision field layout.
package fpseqpkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} SeqStateType;

  // Default single-precision field widths
  localparam int EXP_BITS_DEF  = 8;
  localparam int MANT_BITS_DEF = 23;

  // Exponent field position inside a single-precision word
  localparam int EXP_LSB = MANT_BITS_DEF;
  localparam int EXP_MSB = MANT_BITS_DEF + EXP_BITS_DEF - 1;

  // Quiet NaN for single precision: sign 0, exponent all ones, mantissa MSB set
  localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;

endpackage

// File: rtl/fp_add_sequencer_exp_compare.sv
// Combinational exponent comparator.
// Produces A>B (strict) and the magnitude of the exponent difference.
module exp_compare #(
  parameter int EXPBITS = 8
) (
  input  logic [EXPBITS-1:0] ExpA,
  input  logic [EXPBITS-1:0] ExpB,
  output logic               ExpSet,
  output logic [EXPBITS-1:0] ExpDiff
);

  logic [EXPBITS:0] diff_w;
  logic             borrow_w;

  // One extra bit catches the borrow, which marks exp(B) > exp(A)
  always_comb begin
    diff_w   = {1'b0, ExpA} - {1'b0, ExpB};
    borrow_w = diff_w[EXPBITS];
    ExpSet   = !borrow_w && (|diff_w[EXPBITS-1:0]);
    ExpDiff  = borrow_w ? (ExpB - ExpA) : diff_w[EXPBITS-1:0];
  end

endmodule

// File: rtl/fp_add_sequencer.sv
// FP adder sequencer: initiator side of the adder control handshake.
// Accepts an operand pair, issues a one-cycle Go to the adder control,
// waits for FlagResult, then holds the captured sum on a valid/ready output.
// Optional watchdog on the WAIT state is enabled with `define FP_SEQ_TIMEOUT_EN.
module fp_add_sequencer
  import fpseqpkg::*;
#(
  parameter int EXPBITS      = EXP_BITS_DEF,
  parameter int MANTISSABITS = MANT_BITS_DEF,
  parameter int MAXCYCLES    = 64
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic                            InValid,
  output logic                            InReady,
  input  logic [EXPBITS+MANTISSABITS:0]   OpA,
  input  logic [EXPBITS+MANTISSABITS:0]   OpB,
  output logic [EXPBITS+MANTISSABITS:0]   OperandA,
  output logic [EXPBITS+MANTISSABITS:0]   OperandB,
  output logic                            Go,
  output logic                            ExpSet,
  output logic [EXPBITS-1:0]              ExpDiff,
  output logic [EXPBITS-1:0]              Diff,
  input  logic                            FlagResult,
  input  logic [EXPBITS+MANTISSABITS:0]   ResultIn,
  output logic                            OutValid,
  input  logic                            OutReady,
  output logic [EXPBITS+MANTISSABITS:0]   Result,
`ifdef FP_SEQ_TIMEOUT_EN
  output logic                            TimeoutErr,
  output logic                            CoreReset,
`endif
  output logic                            Busy
);

  localparam int W = 1 + EXPBITS + MANTISSABITS;

  SeqStateType          state_q;
  logic [W-1:0]         opa_q, opb_q, result_q;
  logic                 go_q, exp_set_q, out_valid_q;
  logic [EXPBITS-1:0]   exp_diff_q, diff_q;

  // Comparator output is the next-state value for the exponent registers
  logic                 exp_set_d;
  logic [EXPBITS-1:0]   exp_diff_d;

  exp_compare #(.EXPBITS(EXPBITS)) u_exp_compare (
    .ExpA    (OpA[W-2:MANTISSABITS]),
    .ExpB    (OpB[W-2:MANTISSABITS]),
    .ExpSet  (exp_set_d),
    .ExpDiff (exp_diff_d)
  );

`ifdef FP_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(MAXCYCLES + 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXPBITS{1'b1}}, 1'b1, {(MANTISSABITS-1){1'b0}}};
  logic [CW-1:0] wait_cnt_q;
  logic          timeout_err_q, core_reset_q;
`else
  // Watchdog limit only matters when the timeout feature is built in
  logic unused_maxcycles;
  assign unused_maxcycles = (MAXCYCLES != 0);
`endif

  // Sequencer FSM with all outputs registered
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Reset) begin
      state_q     <= IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      go_q        <= 1'b0;
      exp_set_q   <= 1'b0;
      exp_diff_q  <= '0;
      diff_q      <= '0;
      out_valid_q <= 1'b0;
`ifdef FP_SEQ_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      core_reset_q  <= 1'b0;
`endif
    end else begin
      go_q <= 1'b0;
`ifdef FP_SEQ_TIMEOUT_EN
      core_reset_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (InValid) begin
            opa_q      <= OpA;
            opb_q      <= OpB;
            exp_set_q  <= exp_set_d;
            exp_diff_q <= exp_diff_d;
            diff_q     <= exp_diff_d;
            go_q       <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
`ifdef FP_SEQ_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        WAIT: begin
          // A real result beats a simultaneous watchdog expiry
          if (FlagResult) begin
            result_q    <= ResultIn;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
`ifdef FP_SEQ_TIMEOUT_EN
          else if (wait_cnt_q == CW'(MAXCYCLES - 1)) begin
            result_q      <= QNAN;
            out_valid_q   <= 1'b1;
            timeout_err_q <= 1'b1;
            core_reset_q  <= 1'b1;
            state_q       <= HOLD;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
`endif
        end
        HOLD: begin
          if (out_valid_q && OutReady) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
`ifdef FP_SEQ_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign InReady  = (state_q == IDLE) && !Reset;
  assign Busy     = (state_q != IDLE);
  assign OperandA = opa_q;
  assign OperandB = opb_q;
  assign Go       = go_q;
  assign ExpSet   = exp_set_q;
  assign ExpDiff  = exp_diff_q;
  assign Diff     = diff_q;
  assign Result   = result_q;
  assign OutValid = out_valid_q;
`ifdef FP_SEQ_TIMEOUT_EN
  assign TimeoutErr = timeout_err_q;
  assign CoreReset  = core_reset_q;
`endif

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Self-checking bench for fp_add_sequencer (single precision).
// Table vectors, hand-written corner sequences and randomized operations
// checked against a plain-arithmetic exponent model.
module tb_fp_add_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        InValid, InReady;
  logic [31:0] OpA, OpB, OperandA, OperandB;
  logic        Go, ExpSet;
  logic [7:0]  ExpDiff, Diff;
  logic        FlagResult;
  logic [31:0] ResultIn, Result;
  logic        OutValid, OutReady, Busy;
`ifdef FP_SEQ_TIMEOUT_EN
  logic        TimeoutErr, CoreReset;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  fp_add_sequencer #(.EXPBITS(8), .MANTISSABITS(23), .MAXCYCLES(8)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .InValid    (InValid),
    .InReady    (InReady),
    .OpA        (OpA),
    .OpB        (OpB),
    .OperandA   (OperandA),
    .OperandB   (OperandB),
    .Go         (Go),
    .ExpSet     (ExpSet),
    .ExpDiff    (ExpDiff),
    .Diff       (Diff),
    .FlagResult (FlagResult),
    .ResultIn   (ResultIn),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .Result     (Result),
`ifdef FP_SEQ_TIMEOUT_EN
    .TimeoutErr (TimeoutErr),
    .CoreReset  (CoreReset),
`endif
    .Busy       (Busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exp_set;
    logic [7:0]  exp_diff;
    int          flag_dly;
    int          ready_dly;
    bit          ready_hi;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge Clock);
  endtask

  // Reference: exponents as plain integers
  function automatic int exp_of(input logic [31:0] w);
    return int'(w[30:23]);
  endfunction

  // One full operation; starts and ends at a negedge with the DUT idle
  task automatic do_op(input vec_t v, input string tag);
    check({tag, " in_ready_idle"}, InReady, 1);
    OpA = v.a; OpB = v.b; InValid = 1'b1; OutReady = v.ready_hi;
    step();
    InValid = 1'b0; OpA = $urandom; OpB = $urandom;
    check({tag, " go"}, Go, 1);
    check({tag, " busy"}, Busy, 1);
    check({tag, " in_ready_busy"}, InReady, 0);
    check({tag, " exp_set"}, ExpSet, v.exp_set);
    check({tag, " exp_diff"}, ExpDiff, v.exp_diff);
    check({tag, " diff"}, Diff, v.exp_diff);
    check({tag, " operand_a"}, OperandA, v.a);
    check({tag, " operand_b"}, OperandB, v.b);
    step();
    check({tag, " go_one_cycle"}, Go, 0);
    for (int i = 0; i < v.flag_dly; i++) begin
      step();
      check({tag, " wait_no_valid"}, OutValid, 0);
      check({tag, " wait_exp_diff"}, ExpDiff, v.exp_diff);
    end
    FlagResult = 1'b1; ResultIn = v.res;
    step();
    FlagResult = 1'b0; ResultIn = $urandom;
    check({tag, " out_valid"}, OutValid, 1);
    check({tag, " result"}, Result, v.res);
    check({tag, " operand_a_held"}, OperandA, v.a);
    if (v.ready_hi) begin
      step();
      check({tag, " single_valid"}, OutValid, 0);
      check({tag, " idle_busy"}, Busy, 0);
      step();
      check({tag, " no_dup"}, OutValid, 0);
    end else begin
      for (int i = 0; i < v.ready_dly; i++) begin
        step();
        check({tag, " bp_valid"}, OutValid, 1);
        check({tag, " bp_result"}, Result, v.res);
        check({tag, " bp_in_ready"}, InReady, 0);
      end
      OutReady = 1'b1;
      step();
      OutReady = 1'b0;
      check({tag, " drained_valid"}, OutValid, 0);
      check({tag, " drained_in_ready"}, InReady, 1);
      check({tag, " drained_busy"}, Busy, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t tbl[5];
    vec_t rv;
    logic [31:0] last_res;

    Reset = 1'b1; InValid = 1'b0; OpA = '0; OpB = '0;
    FlagResult = 1'b0; ResultIn = '0; OutReady = 1'b0;
    repeat (3) step();
    check("reset in_ready", InReady, 0);
    check("reset out_valid", OutValid, 0);
    check("reset result", Result, 0);
    check("reset operand_a", OperandA, 0);
    check("reset go", Go, 0);
    check("reset busy", Busy, 0);
    check("reset exp_diff", ExpDiff, 0);
    Reset = 1'b0;
    step();

    // a, b, res, exp_set, exp_diff, flag_dly, ready_dly, ready_hi
    tbl[0] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 8'd1,   0, 0, 1'b0};
    tbl[1] = '{32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 8'd0,   2, 1, 1'b0};
    tbl[2] = '{32'h4B00_0000, 32'h3F80_0000, 32'h4B00_0001, 1'b1, 8'd23,  1, 5, 1'b0};
    tbl[3] = '{32'h0000_0000, 32'h7F80_0000, 32'h7F80_0000, 1'b0, 8'd255, 3, 0, 1'b1};
    tbl[4] = '{32'hFF80_0000, 32'h0000_0001, 32'hFF80_0000, 1'b1, 8'd255, 0, 2, 1'b0};
    for (int i = 0; i < 5; i++) do_op(tbl[i], $sformatf("vec%0d", i));
    last_res = tbl[4].res;

    // FlagResult in IDLE is ignored
    FlagResult = 1'b1; ResultIn = 32'hDEAD_BEEF;
    step();
    FlagResult = 1'b0;
    check("idle_flag out_valid", OutValid, 0);
    check("idle_flag result", Result, last_res);
    check("idle_flag busy", Busy, 0);

    // FlagResult in HOLD is ignored
    OpA = 32'h4000_0000; OpB = 32'h3F80_0000; InValid = 1'b1;
    step();
    InValid = 1'b0;
    step();
    FlagResult = 1'b1; ResultIn = 32'h1234_5678;
    step();
    ResultIn = 32'hCAFE_F00D;
    step();
    FlagResult = 1'b0;
    check("hold_flag result", Result, 32'h1234_5678);
    check("hold_flag out_valid", OutValid, 1);
    OutReady = 1'b1;
    step();
    OutReady = 1'b0;
    check("hold_flag drained", OutValid, 0);

    // Reset while waiting drops the operation
    OpA = 32'h4080_0000; OpB = 32'h3F80_0000; InValid = 1'b1;
    step();
    InValid = 1'b0;
    step();
    Reset = 1'b1;
    step();
    check("rst_wait in_ready", InReady, 0);
    Reset = 1'b0;
    check("rst_wait busy", Busy, 0);
    check("rst_wait out_valid", OutValid, 0);
    check("rst_wait result", Result, 0);
    check("rst_wait operand_a", OperandA, 0);
    check("rst_wait exp_set", ExpSet, 0);
    check("rst_wait diff", Diff, 0);
    FlagResult = 1'b1; ResultIn = 32'h4100_0000;
    step();
    FlagResult = 1'b0;
    check("rst_wait late_flag", OutValid, 0);
    step();

    // Randomized operations against the integer exponent model
    for (int i = 0; i < 24; i++) begin
      int ea, eb;
      rv.a = $urandom; rv.b = $urandom; rv.res = $urandom;
      if (i % 5 == 0) rv.b[30:23] = rv.a[30:23];
      ea = exp_of(rv.a); eb = exp_of(rv.b);
      rv.exp_set   = (ea > eb);
      rv.exp_diff  = 8'((ea > eb) ? (ea - eb) : (eb - ea));
      rv.flag_dly  = int'($urandom_range(0, 4));
      rv.ready_dly = int'($urandom_range(0, 3));
      rv.ready_hi  = ($urandom_range(0, 3) == 0);
      do_op(rv, $sformatf("rnd%0d", i));
    end

`ifdef FP_SEQ_TIMEOUT_EN
    // Watchdog expiry with MAXCYCLES=8
    OpA = 32'h3F80_0000; OpB = 32'h4000_0000; InValid = 1'b1;
    step();
    InValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("timeout pending", OutValid, 0);
    end
    step();
    check("timeout out_valid", OutValid, 1);
    check("timeout result", Result, 32'h7FC0_0000);
    check("timeout err", TimeoutErr, 1);
    check("timeout core_reset", CoreReset, 1);
    step();
    check("timeout core_reset_pulse", CoreReset, 0);
    OutReady = 1'b1;
    step();
    OutReady = 1'b0;
    check("timeout err_cleared", TimeoutErr, 0);
    check("timeout drained", OutValid, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
- Initiator side of the adder control handshake.
- Accepts an IEEE-754 single-precision operand pair over a valid/ready input channel, registers it, and computes exponent compare/difference.
- Issues a one-cycle Go to the adder control FSM, waits for its FlagResult, captures the datapath result, and presents it on a valid/ready output channel.
- Sits between the host/bus interface and the adder core (control FSM plus datapath).

Parameters:
- EXPBITS, 8, exponent field width.
- MANTISSABITS, 23, mantissa field width; word width W = 1+EXPBITS+MANTISSABITS.
- MAXCYCLES, 64, watchdog limit in cycles. Used only with the optional feature.

Ports:
- Clock  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- InValid  in  1  operand pair valid.
- InReady  out  1  sequencer can accept a pair.
- OpA  in  W  operand A.
- OpB  in  W  operand B.
- OperandA  out  W  registered A to datapath; stable from ISSUE until FlagResult.
- OperandB  out  W  registered B to datapath; same stability as OperandA.
- Go  out  1  one-cycle start pulse to control.
- ExpSet  out  1  1 when exp(A) > exp(B).
- ExpDiff  out  EXPBITS  |exp(A) - exp(B)|.
- Diff  out  EXPBITS  copy of ExpDiff, used as shift amount.
- FlagResult  in  1  control done strobe.
- ResultIn  in  W  datapath sum, valid while FlagResult=1.
- OutValid  out  1  result valid.
- OutReady  in  1  consumer accepts result.
- Result  out  W  captured sum.
- Busy  out  1  state != IDLE.

Behaviour:
- Reset: synchronous, active-high; clock Clock. Reset forces state IDLE and clears OperandA, OperandB, ExpSet, ExpDiff, Diff, Result and OutValid to 0. Go=0 and Busy=0.
- InReady = (state==IDLE) && !Reset, so it is 0 while Reset is high.
- States are IDLE, ISSUE, WAIT and HOLD.
- IDLE: on InValid && InReady, register OpA/OpB. Compute ExpSet, ExpDiff and Diff from the exponent fields [W-2:MANTISSABITS] and register them in the same edge. Go to ISSUE.
- ISSUE: Go=1 for exactly this one cycle, then go to WAIT. ExpSet, ExpDiff, Diff and the operand outputs are held constant until the state leaves WAIT.
- WAIT: on FlagResult=1, capture ResultIn into Result, set OutValid=1 and go to HOLD. FlagResult in any other state is ignored.
- HOLD: Result and OutValid are held. On OutValid && OutReady, clear OutValid and go to IDLE. A new input is accepted no earlier than the next cycle; there is no same-cycle pass-through.
- Exponent arithmetic: unsigned subtract with a 1-bit-wider intermediate. ExpSet is the strict greater-than. When exponents are equal, ExpDiff=0 and ExpSet=0.
- Latency: input handshake edge to OutValid = 2 cycles + core latency. Go is issued 1 cycle after acceptance.
- Issue spacing is guaranteed by the FSM: Go occurs at least 2 cycles after the previous FlagResult, so control is back in IDLE.
- Reset mid-operation (ISSUE, WAIT or HOLD): the in-flight result is dropped and nothing is presented.
- OutReady held at 1 continuously: one result per operation, never duplicated.

Optional Feature:
- Macro: FP_SEQ_TIMEOUT_EN.
- Defined:
  - A cycle counter ($clog2(MAXCYCLES+1) bits) clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches MAXCYCLES without FlagResult, Result = {1'b0, all-ones exponent, 1'b1, zeros} (quiet NaN) and output TimeoutErr=1 alongside OutValid. Go to HOLD.
  - Output CoreReset pulses 1 for that cycle to restart control. TimeoutErr clears on output handshake.
  - FlagResult arriving in the same cycle as expiry wins, and no timeout is flagged.
- Undefined: no counter, no TimeoutErr/CoreReset ports; WAIT waits indefinitely.

Decomposition:
- Package fpseqpkg holds:
  - typedef enum logic [1:0] SeqStateType {IDLE, ISSUE, WAIT, HOLD};
  - localparams for the exponent field position and the QNaN constant.
- Sub-module exp_compare: combinational; exponents A/B in, ExpSet/ExpDiff out. Instantiated once.

Test Plan:
- Basic issue: A=0x3F800000, B=0x40000000 -> ExpSet=0, ExpDiff=Diff=1, Go high exactly 1 cycle after acceptance. FlagResult with ResultIn=0x40400000 -> Result=0x40400000, OutValid next cycle.
- Equal exponents: A=B=0x3F800000 -> ExpDiff=0, ExpSet=0.
- Large difference: A=0x4B000000, B=0x3F800000 -> ExpSet=1, ExpDiff=23.
- Backpressure: OutReady=0 for 5 cycles -> Result/OutValid stable, InReady=0. OutReady=1 -> IDLE next cycle, InReady=1.
- Spurious/late events: FlagResult pulsed in IDLE or HOLD -> ignored, no output change. Reset asserted in WAIT -> IDLE, OutValid never asserts, all outputs 0.
- (FP_SEQ_TIMEOUT_EN, MAXCYCLES=8) No FlagResult -> after 8 WAIT cycles OutValid=1, Result=0x7FC00000, TimeoutErr=1, CoreReset pulse of 1 cycle.
